// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and default timing constants,
// common to the transmitter and the matching receiver.
package uart_tx_pkg;

   localparam int N_BITS_DEF     = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int BAUD_DIV_DEF   = 326;   // 50 MHz / (9600 baud * 16)

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_baud_rate_gen.sv
// Oversampling baud tick generator: a one-cycle tick every BAUD_DIV clocks,
// restartable with clear so a new frame begins on a full baud period.
module baud_rate_gen #(
   parameter int BAUD_DIV = 326
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             tick_r;

   // Next divider count: restart on clear or at the terminal count.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear) begin
         cnt_next_s = '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
   end

   // Tick is registered from the next count so it is high exactly while cnt_r is terminal.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         tick_r <= (cnt_next_s == CNT_LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: accepts a byte on a start strobe, sends it LSB first
// with start/stop framing, and pulses tx_done when the stop bit completes.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int N_BITS     = N_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int BAUD_DIV   = BAUD_DIV_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              tx_start,
   input  logic [N_BITS-1:0] data_in,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(N_BITS);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N_BITS - 1);

   logic [1:0]        state_r,    state_next_s;
   logic [TICK_W-1:0] tick_cnt_r, tick_cnt_next_s;
   logic [BIT_W-1:0]  bit_idx_r,  bit_idx_next_s;
   logic [N_BITS-1:0] shift_r,    shift_next_s;
   logic              tx_r,       tx_next_s;
   logic              busy_r,     busy_next_s;
   logic              done_r,     done_next_s;
   logic              clear_s;
   logic              tick_s;
   logic              last_tick_s;

   baud_rate_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear_s),
      .tick    (tick_s)
   );

   assign last_tick_s = tick_s && (tick_cnt_r == LAST_TICK);

   // Next-state and next-output logic for the framing FSM.
   always_comb begin
      state_next_s    = state_r;
      bit_idx_next_s  = bit_idx_r;
      shift_next_s    = shift_r;
      tx_next_s       = tx_r;
      busy_next_s     = busy_r;
      done_next_s     = 1'b0;
      clear_s         = 1'b0;
      if (tick_s) begin
         tick_cnt_next_s = last_tick_s ? '0 : tick_cnt_r + TICK_W'(1);
      end else begin
         tick_cnt_next_s = tick_cnt_r;
      end

      case (state_r)
         ST_IDLE: begin
            tick_cnt_next_s = '0;
            if (tx_start) begin
               state_next_s   = ST_START;
               shift_next_s   = data_in;
               tx_next_s      = 1'b0;
               busy_next_s    = 1'b1;
               bit_idx_next_s = '0;
               clear_s        = 1'b1;
            end else begin
               bit_idx_next_s = '0;
            end
         end
         ST_START: begin
            if (last_tick_s) begin
               state_next_s   = ST_DATA;
               tx_next_s      = shift_r[0];
               bit_idx_next_s = '0;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_DATA: begin
            if (last_tick_s) begin
               if (bit_idx_r == LAST_BIT) begin
                  state_next_s   = ST_STOP;
                  tx_next_s      = 1'b1;
                  bit_idx_next_s = '0;
               end else begin
                  shift_next_s   = {1'b0, shift_r[N_BITS-1:1]};
                  tx_next_s      = shift_r[1];
                  bit_idx_next_s = bit_idx_r + BIT_W'(1);
               end
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (last_tick_s) begin
               state_next_s = ST_IDLE;
               busy_next_s  = 1'b0;
               done_next_s  = 1'b1;
            end else begin
               state_next_s = ST_STOP;
            end
         end
         default: begin
            state_next_s    = ST_IDLE;
            tick_cnt_next_s = '0;
            bit_idx_next_s  = '0;
            tx_next_s       = 1'b1;
            busy_next_s     = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame and idles the line high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         tick_cnt_r <= '0;
         bit_idx_r  <= '0;
         shift_r    <= '0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         tick_cnt_r <= tick_cnt_next_s;
         bit_idx_r  <= bit_idx_next_s;
         shift_r    <= shift_next_s;
         tx_r       <= tx_next_s;
         busy_r     <= busy_next_s;
         done_r     <= done_next_s;
      end
   end

   assign tx      = tx_r;
   assign tx_busy = busy_r;
   assign tx_done = done_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that returns ALU results to the host PC as UART 8N1 frames.
- Sits between the ALU result register and the board TX pin.
- Replaces LED-only output: a byte is accepted on a one-cycle start strobe, serialised LSB first, and completion is reported with a done pulse.
- Contains its own x16 oversampling baud tick generator so its timing matches the team's UART receiver.

Parameters:
- N_BITS, 8, data bits per frame (same width as the ALU datapath).
- OVERSAMPLE, 16, baud ticks per bit period.
- BAUD_DIV, 326, clock cycles per baud tick (50 MHz clock, 9600 baud, x16).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  N_BITS  byte to send (ALU result, two's complement bits sent unchanged).
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (asynchronous, reset_n low):
  - tx=1, tx_busy=0, tx_done=0.
  - State IDLE; baud counter, tick counter, bit index and shift register cleared.
  - A reset mid-frame aborts the frame. The line returns high immediately; no tx_done is generated.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
- Baud tick:
  - Counter runs 0..BAUD_DIV-1; tick is asserted for one cycle when the count is BAUD_DIV-1.
  - The counter is forced to 0 on the cycle a frame is accepted, so every bit lasts exactly OVERSAMPLE*BAUD_DIV cycles.
- IDLE:
  - On an edge with tx_start=1: shift register<=data_in, state<=START, tx<=0, tx_busy<=1, tick count<=0.
  - Latency: tx falls on the edge that samples tx_start.
- START: after OVERSAMPLE ticks, go to DATA; tx<=shift[0]; bit index<=0.
- DATA:
  - Every OVERSAMPLE ticks, shift right and drive tx with the new LSB.
  - After bit N_BITS-1 has been held for its full period, go to STOP with tx<=1.
- STOP:
  - After OVERSAMPLE ticks: state<=IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle.
  - tx stays 1.
- Frame length: (N_BITS+2)*OVERSAMPLE*BAUD_DIV cycles from the accepting edge to the tx_done edge.
- tx_start while tx_busy=1 is ignored. It is not queued, and data_in changes have no effect on the frame in flight.
- tx_start high on the cycle tx_done is high is accepted (state is IDLE). This gives back-to-back frames with a one-cycle high gap.
- tx_start held high continuously sends repeated frames of the current data_in.
- The tick counter and bit index never wrap past their terminal values; each is reset on every state transition.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the default BAUD_DIV and OVERSAMPLE constants, shared with the receiver.
- One sub-module, baud_rate_gen:
  - parameter BAUD_DIV;
  - ports clock, reset_n, clear, tick.
  - The same generator instance type is reused by the receiver.

Test Plan (all use BAUD_DIV=2, OVERSAMPLE=16, so one bit = 32 cycles and one frame = 320 cycles):
- Reset check: reset_n=0, then release -> tx=1, tx_busy=0, tx_done=0; no activity for 1000 cycles with tx_start=0.
- Send 8'hA5:
  - tx reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 32 cycles.
  - tx_busy is high for 320 cycles.
  - tx_done pulses once on cycle 320 after the accepting edge.
- Send signed -8 (8'hF8): data bits observed LSB first are 0,0,0,1,1,1,1,1; the captured byte equals 8'hF8.
- Busy rejection:
  - Start 8'h3C, then pulse tx_start with data_in=8'hFF at cycle 100.
  - The frame still carries 8'h3C, and exactly one tx_done pulse occurs.
- Back-to-back:
  - Assert tx_start with 8'h00 and hold it; switch data_in to 8'hFF during the first frame.
  - The second frame's start bit begins exactly 1 cycle after tx_done.
  - The frames carry 8'h00 then 8'hFF.
- Mid-frame reset:
  - Assert reset_n=0 at cycle 150 of an 8'h55 frame -> tx goes to 1 asynchronously, tx_busy=0, no tx_done.
  - A new 8'h81 frame after release is transmitted correctly.
